conv_window_gen: RTL and testbench

Synthesisable sliding-window generator that replaces bench-side window slicing in front of simpleCNN. It accepts one frame as a raster pixel stream and emits every KxK window as a packed bus with valid/ready handshake. Image size, kernel size, pixel width and stride are parametrised. Output packing matches the IMGIN layout simpleCNN consumes.

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/line_buffer.sv | 26 ++
 rtl/conv_window_gen.sv | 213 +++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the sliding-window generator: width helpers,
// per-frame window-count arithmetic and the controller state encodings.
package conv_pkg;

    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int winXWidth(input int imgH);
        return clog2(imgH);
    endfunction

    function automatic int winYWidth(input int imgW);
        return clog2(imgW);
    endfunction

    function automatic int winCount(input int imgW, input int imgH, input int k, input int stride);
        return ((imgH - k) / stride + 1) * ((imgW - k) / stride + 1);
    endfunction

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_K      = 5;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_STRIDE = 1;

    localparam int DEF_WIN_COUNT = winCount(DEF_IMG_W, DEF_IMG_H, DEF_K, DEF_STRIDE);
    localparam int DEF_WIN_X_W   = winXWidth(DEF_IMG_H);
    localparam int DEF_WIN_Y_W   = winYWidth(DEF_IMG_W);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage; the read at the current column sees the
// previous row's pixel before this cycle's write replaces it.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                     CLK,
    input  logic [clog2(IMG_W)-1:0]  addr_i,
    input  logic                     we_i,
    input  logic [PIX_W-1:0]         wdata_i,
    output logic [PIX_W-1:0]         rdata_o
);

    logic [PIX_W-1:0] mem_q [IMG_W];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge CLK) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream in, every stride-aligned KxK window out as a packed bus
// (byte i*K+j = pixel at window row i, column j) with a valid/ready handshake.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int STRIDE = DEF_STRIDE
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         START,
    input  logic [PIX_W-1:0]             PIX_IN,
    input  logic                         PIX_VALID,
    output logic                         PIX_READY,
    output logic [K*K*PIX_W-1:0]         WIN_OUT,
    output logic                         WIN_VALID,
    input  logic                         WIN_READY,
    output logic [winXWidth(IMG_H)-1:0]  WIN_X,
    output logic [winYWidth(IMG_W)-1:0]  WIN_Y,
    output logic                         FRAME_DONE,
    output logic                         BUSY
);

    localparam int RW = winXWidth(IMG_H);
    localparam int CW = winYWidth(IMG_W);
    localparam int PW = clog2(STRIDE);

    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);
    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
    localparam logic [PW-1:0] PHASE_LAST    = PW'(STRIDE - 1);

    logic [1:0]           state_q, state_d;
    logic [RW-1:0]        rowCnt_q, rowCnt_d;
    logic [CW-1:0]        colCnt_q, colCnt_d;
    logic [PW-1:0]        rowPhase_q, rowPhase_d;
    logic [PW-1:0]        colPhase_q, colPhase_d;
    logic                 winValid_q, winValid_d;
    logic [K*K*PIX_W-1:0] winOut_q, winOut_d;
    logic [RW-1:0]        winX_q, winX_d;
    logic [CW-1:0]        winY_q, winY_d;

    logic                 pixReady;
    logic                 accept;
    logic                 lastPix;
    logic                 rowInWin;
    logic                 colInWin;
    logic                 emit;

    logic [PIX_W-1:0]     lbRd [K-1];
    logic [PIX_W-1:0]     win_q [K][K];
    logic [PIX_W-1:0]     winShift [K][K];
    logic [K*K*PIX_W-1:0] winPacked;

    // A pending window that is not being taken this cycle blocks input, so a
    // completing pixel can never overwrite an unconsumed window.
    assign pixReady = (state_q == ST_RUN) && (!winValid_q || WIN_READY);
    assign accept   = PIX_VALID && pixReady;
    assign lastPix  = accept && (rowCnt_q == ROW_LAST) && (colCnt_q == COL_LAST);
    assign rowInWin = (rowCnt_q >= ROW_FIRST_WIN);
    assign colInWin = (colCnt_q >= COL_FIRST_WIN);
    assign emit     = accept && rowInWin && colInWin
                      && (rowPhase_q == '0) && (colPhase_q == '0);

    // Buffer m holds row r-1-m; each buffer forwards its old pixel to the next.
    for (genvar m = 0; m < K - 1; m++) begin : g_lb
        logic [PIX_W-1:0] wdata;
        if (m == 0) begin : g_head
            assign wdata = PIX_IN;
        end else begin : g_tail
            assign wdata = lbRd[m-1];
        end
        line_buffer #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W)
        ) u_lb (
            .CLK     (CLK),
            .addr_i  (colCnt_q),
            .we_i    (accept),
            .wdata_i (wdata),
            .rdata_o (lbRd[m])
        );
    end

    // Window shifts left; the incoming column is oldest row at the top down to PIX_IN.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                winShift[i][j] = win_q[i][j+1];
            end
        end
        for (int i = 0; i < K - 1; i++) begin
            winShift[i][K-1] = lbRd[K-2-i];
        end
        winShift[K-1][K-1] = PIX_IN;
    end

    always_comb begin
        winPacked = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                winPacked[(i*K+j)*PIX_W +: PIX_W] = winShift[i][j];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            win_q <= winShift;
        end
    end

    // Phase counters start counting only once a full kernel fits, so phase zero
    // marks positions whose offset from the first window is a stride multiple.
    always_comb begin
        state_d    = state_q;
        rowCnt_d   = rowCnt_q;
        colCnt_d   = colCnt_q;
        rowPhase_d = rowPhase_q;
        colPhase_d = colPhase_q;
        winValid_d = winValid_q;
        winOut_d   = winOut_q;
        winX_d     = winX_q;
        winY_d     = winY_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d    = ST_RUN;
                    rowCnt_d   = '0;
                    colCnt_d   = '0;
                    rowPhase_d = '0;
                    colPhase_d = '0;
                end
            end
            ST_RUN: begin
                if (lastPix) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!winValid_q || WIN_READY) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            if (colCnt_q == COL_LAST) begin
                colCnt_d   = '0;
                colPhase_d = '0;
                rowCnt_d   = rowCnt_q + 1'b1;
                if (rowInWin) begin
                    rowPhase_d = (rowPhase_q == PHASE_LAST) ? '0 : rowPhase_q + 1'b1;
                end
            end else begin
                colCnt_d = colCnt_q + 1'b1;
                if (colInWin) begin
                    colPhase_d = (colPhase_q == PHASE_LAST) ? '0 : colPhase_q + 1'b1;
                end
            end
        end

        if (emit) begin
            winValid_d = 1'b1;
            winOut_d   = winPacked;
            winX_d     = rowCnt_q - ROW_FIRST_WIN;
            winY_d     = colCnt_q - COL_FIRST_WIN;
        end else if (winValid_q && WIN_READY) begin
            winValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= ST_IDLE;
            rowCnt_q   <= '0;
            colCnt_q   <= '0;
            rowPhase_q <= '0;
            colPhase_q <= '0;
            winValid_q <= 1'b0;
            winOut_q   <= '0;
            winX_q     <= '0;
            winY_q     <= '0;
        end else begin
            state_q    <= state_d;
            rowCnt_q   <= rowCnt_d;
            colCnt_q   <= colCnt_d;
            rowPhase_q <= rowPhase_d;
            colPhase_q <= colPhase_d;
            winValid_q <= winValid_d;
            winOut_q   <= winOut_d;
            winX_q     <= winX_d;
            winY_q     <= winY_d;
        end
    end

    assign PIX_READY  = pixReady;
    assign WIN_OUT    = winOut_q;
    assign WIN_VALID  = winValid_q;
    assign WIN_X      = winX_q;
    assign WIN_Y      = winY_q;
    assign FRAME_DONE = (state_q == ST_DONE);
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 6x6/K3 at stride 1 and 2, stalled
// downstream, restart attempts, a full 28x28/K5 frame and a mid-frame reset.
module tb_conv_window_gen;
    import conv_pkg::*;

    typedef struct {
        int           x;
        int           y;
        logic [255:0] w;
    } rec_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       nRST;
    logic [7:0] pixIn;
    logic       pixValid;
    logic       winReady;
    logic       startA, startB, startC;

    logic        pixReadyA, winValidA, frameDoneA, busyA;
    logic [71:0] winOutA;
    logic [2:0]  winXA, winYA;
    logic        pixReadyB, winValidB, frameDoneB, busyB;
    logic [71:0] winOutB;
    logic [2:0]  winXB, winYB;
    logic        pixReadyC, winValidC, frameDoneC, busyC;
    logic [199:0] winOutC;
    logic [DEF_WIN_X_W-1:0] winXC;
    logic [DEF_WIN_Y_W-1:0] winYC;

    rec_t qA[$];
    rec_t qB[$];
    rec_t qC[$];
    int   doneA, doneB, doneC;
    int   cyc;
    int   lastPixCyc, doneCyc;
    int   errors, checks;
    bit   randMode, stallMode;
    logic prevStall;
    logic [78:0] prevA;

    conv_window_gen #(.IMG_W(6), .IMG_H(6), .K(3), .PIX_W(8), .STRIDE(1)) dutA (
        .CLK(CLK), .nRST(nRST), .START(startA), .PIX_IN(pixIn), .PIX_VALID(pixValid),
        .PIX_READY(pixReadyA), .WIN_OUT(winOutA), .WIN_VALID(winValidA), .WIN_READY(winReady),
        .WIN_X(winXA), .WIN_Y(winYA), .FRAME_DONE(frameDoneA), .BUSY(busyA));

    conv_window_gen #(.IMG_W(6), .IMG_H(6), .K(3), .PIX_W(8), .STRIDE(2)) dutB (
        .CLK(CLK), .nRST(nRST), .START(startB), .PIX_IN(pixIn), .PIX_VALID(pixValid),
        .PIX_READY(pixReadyB), .WIN_OUT(winOutB), .WIN_VALID(winValidB), .WIN_READY(winReady),
        .WIN_X(winXB), .WIN_Y(winYB), .FRAME_DONE(frameDoneB), .BUSY(busyB));

    conv_window_gen dutC (
        .CLK(CLK), .nRST(nRST), .START(startC), .PIX_IN(pixIn), .PIX_VALID(pixValid),
        .PIX_READY(pixReadyC), .WIN_OUT(winOutC), .WIN_VALID(winValidC), .WIN_READY(winReady),
        .WIN_X(winXC), .WIN_Y(winYC), .FRAME_DONE(frameDoneC), .BUSY(busyC));

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pixVal(input int sel, input int r, input int c);
        return (sel == 0) ? (r * 6 + c) : ((r * 28 + c) % 256);
    endfunction

    always @(posedge CLK) cyc++;

    always @(posedge CLK) begin
        if (randMode) begin
            #1;
            winReady = 1'($urandom_range(0, 1));
        end
    end

    // Capture consumed windows, count done pulses and watch stalled outputs.
    always @(negedge CLK) begin
        if (winValidA && winReady) qA.push_back('{x: int'(winXA), y: int'(winYA), w: 256'(winOutA)});
        if (winValidB && winReady) qB.push_back('{x: int'(winXB), y: int'(winYB), w: 256'(winOutB)});
        if (winValidC && winReady) qC.push_back('{x: int'(winXC), y: int'(winYC), w: 256'(winOutC)});
        if (frameDoneA) doneA++;
        if (frameDoneB) doneB++;
        if (frameDoneC) doneC++;
        if (stallMode) begin
            if (prevStall) checkOutput("stall_hold", {winValidA, winXA, winYA, winOutA}, prevA);
            if (winValidA && !winReady && busyA) checkOutput("stall_pixready", pixReadyA, 0);
            prevStall = winValidA && !winReady;
            prevA     = {winValidA, winXA, winYA, winOutA};
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic applyStimulus(input int sel, input int nPix, input int startAt);
        int w;
        w = (sel == 0) ? 6 : 28;
        for (int p = 0; p < nPix; p++) begin
            int budget;
            pixIn    = 8'(pixVal(sel, p / w, p % w));
            pixValid = 1'b1;
            if (sel == 0 && p == startAt) startA = 1'b1;
            budget = 0;
            do begin
                @(negedge CLK);
                budget++;
            end while (!((sel == 0) ? pixReadyA : pixReadyC) && budget < 200);
            if (!((sel == 0) ? pixReadyA : pixReadyC)) begin
                checkOutput("pix_timeout", 0, 1);
                pixValid = 1'b0;
                startA   = 1'b0;
                return;
            end
            lastPixCyc = cyc;
            @(posedge CLK);
            #1;
            startA = 1'b0;
        end
        pixValid = 1'b0;
    endtask

    task automatic waitDone(input int sel, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge CLK);
            n++;
            seen = (sel == 0) ? frameDoneA : frameDoneC;
        end
        checkOutput(tag, seen, 1);
        doneCyc = cyc;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic verifyFrame(input string tag, input rec_t q[$], input int sel,
                               input int w, input int h, input int k, input int s);
        int idx;
        idx = 0;
        checkOutput({tag, "_count"}, q.size(), ((h - k) / s + 1) * ((w - k) / s + 1));
        for (int x = 0; x <= h - k; x += s) begin
            for (int y = 0; y <= w - k; y += s) begin
                if (idx < q.size()) begin
                    logic [255:0] ew;
                    ew = '0;
                    for (int i = 0; i < k; i++)
                        for (int j = 0; j < k; j++)
                            ew[(i*k+j)*8 +: 8] = 8'(pixVal(sel, x + i, y + j));
                    checkOutput({tag, "_xy"}, q[idx].x * 256 + q[idx].y, x * 256 + y);
                    checkOutput({tag, "_win"}, q[idx].w, ew);
                end
                idx++;
            end
        end
    endtask

    task automatic pulseStart(input int sel);
        if (sel == 0) startA = 1'b1; else startC = 1'b1;
        @(posedge CLK);
        #1;
        startA = 1'b0;
        startC = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        errors = 0; checks = 0; cyc = 0;
        doneA = 0; doneB = 0; doneC = 0;
        randMode = 1'b0; stallMode = 1'b0; prevStall = 1'b0;
        nRST = 1'b1; pixIn = '0; pixValid = 1'b0; winReady = 1'b1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        #3 nRST = 1'b0;
        #5;
        checkOutput("reset_A", {pixReadyA, winValidA, winOutA, winXA, winYA, frameDoneA, busyA}, 0);
        checkOutput("reset_C", {pixReadyC, winValidC, winOutC, winXC, winYC, frameDoneC, busyC}, 0);
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;

        // Stride 1 and stride 2 on the same 6x6 ramp, running in lockstep.
        startA = 1'b1; startB = 1'b1;
        @(posedge CLK); #1;
        startA = 1'b0; startB = 1'b0;
        checkOutput("busy_after_start", {busyA, busyB}, 2'b11);
        applyStimulus(0, 36, -1);
        waitDone(0, "t1_done");
        checkOutput("t1_doneA_count", doneA, 1);
        checkOutput("t1_doneB_count", doneB, 1);
        checkOutput("t1_idle", {busyA, busyB}, 0);
        verifyFrame("t1A", qA, 0, 6, 6, 3, 1);
        verifyFrame("t2B", qB, 0, 6, 6, 3, 2);
        checkOutput("t1_first", (qA.size() > 0) ? qA[0].w : '0, 256'h0E0D0C080706020100);
        checkOutput("t1_last", (qA.size() > 0) ? qA[qA.size()-1].w : '0, 256'h2322211D1C1B171615);
        checkOutput("t2_win22_b0", (qB.size() > 3) ? qB[3].w[7:0] : 8'h0, 8'h0E);
        checkOutput("t2_win22_b8", (qB.size() > 3) ? qB[3].w[71:64] : 8'h0, 8'h1C);

        // Downstream stalls at random.
        qA.delete(); doneA = 0;
        stallMode = 1'b1; randMode = 1'b1;
        pulseStart(0);
        applyStimulus(0, 36, -1);
        waitDone(0, "t3_done");
        randMode = 1'b0;
        @(posedge CLK); #2;
        winReady = 1'b1; stallMode = 1'b0;
        verifyFrame("t3A", qA, 0, 6, 6, 3, 1);

        // START during RUN must be ignored.
        qA.delete(); doneA = 0;
        pulseStart(0);
        applyStimulus(0, 36, 10);
        waitDone(0, "t6_done");
        repeat (20) @(posedge CLK);
        #1;
        checkOutput("t6_single_done", doneA, 1);
        verifyFrame("t6A", qA, 0, 6, 6, 3, 1);

        // Full-size frame with default parameters.
        qC.delete(); doneC = 0;
        pulseStart(1);
        applyStimulus(1, 784, -1);
        waitDone(1, "t4_done");
        verifyFrame("t4C", qC, 1, 28, 28, 5, 1);
        checkOutput("t4_count_576", qC.size(), DEF_WIN_COUNT);
        checkOutput("t4_last_xy", (qC.size() > 0) ? (qC[qC.size()-1].x * 256 + qC[qC.size()-1].y) : 0, 23 * 256 + 23);
        checkOutput("t4_done_after_last", doneCyc > lastPixCyc, 1);
        checkOutput("t4_done_count", doneC, 1);

        // Reset partway through a frame, then a clean restart.
        pulseStart(1);
        applyStimulus(1, 100, -1);
        nRST = 1'b0;
        #1;
        checkOutput("t5_rst_outputs", {pixReadyC, winValidC, winOutC, winXC, winYC, frameDoneC, busyC}, 0);
        pixValid = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        @(posedge CLK); #1;
        checkOutput("t5_idle_no_start", {busyC, pixReadyC}, 0);
        qC.delete(); doneC = 0;
        pulseStart(1);
        applyStimulus(1, 784, -1);
        waitDone(1, "t5_done");
        verifyFrame("t5C", qC, 1, 28, 28, 5, 1);
        checkOutput("t5_done_count", doneC, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
